// File: rtl/watch_pkg.sv
// Shared types and helpers for the watch time-entry path: FSM states,
// digit positions, per-position limits and BCD nibble packing.
package watch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENTRY  = 2'd1,
      ST_COMMIT = 2'd2
   } state_e;

   localparam logic [2:0] POS_H_TEN = 3'd0;
   localparam logic [2:0] POS_H_ONE = 3'd1;
   localparam logic [2:0] POS_M_TEN = 3'd2;
   localparam logic [2:0] POS_M_ONE = 3'd3;
   localparam logic [2:0] POS_S_TEN = 3'd4;
   localparam logic [2:0] POS_S_ONE = 3'd5;

   localparam logic [3:0] LIM_H_TEN      = 4'd2;
   localparam logic [3:0] LIM_H_ONE      = 4'd9;
   localparam logic [3:0] LIM_H_ONE_20S  = 4'd3;
   localparam logic [3:0] LIM_TEN        = 4'd5;
   localparam logic [3:0] LIM_ONE        = 4'd9;

   // Largest digit allowed at a position; hours-ones depends on hours-tens.
   function automatic logic [3:0] digit_limit(input logic [2:0] pos, input logic [3:0] h_ten);
      logic [3:0] lim;
      case (pos)
         POS_H_TEN:            lim = LIM_H_TEN;
         POS_H_ONE:            lim = (h_ten == 4'd2) ? LIM_H_ONE_20S : LIM_H_ONE;
         POS_M_TEN, POS_S_TEN: lim = LIM_TEN;
         default:              lim = LIM_ONE;
      endcase
      return lim;
   endfunction

   // Position 0 is the most significant nibble, [23:20].
   function automatic logic [23:0] put_nibble(input logic [23:0] word, input logic [2:0] pos,
                                              input logic [3:0] digit);
      logic [23:0] w;
      int          idx;
      w   = word;
      idx = 20 - 4 * int'(pos);
      w[idx +: 4] = digit;
      return w;
   endfunction

   function automatic logic [3:0] h_ten_of(input logic [23:0] word);
      return word[23:20];
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad front end: two-flop synchronizer, stability counter with release
// tracking, and one-hot to digit encoding. key_evt is a one-cycle strobe.
module key_debounce #(
   parameter int DEBOUNCE = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] keypad,
   output logic       key_evt,
   output logic [3:0] key_digit
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   logic [9:0]    sync1_q, sync1_d;
   logic [9:0]    sync2_q, sync2_d;
   logic [9:0]    samp_q, samp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          armed_q, armed_d;
   logic          evt_q, evt_d;
   logic [3:0]    digit_q, digit_d;

   function automatic logic [3:0] encode(input logic [9:0] v);
      logic [3:0] d;
      d = 4'd0;
      for (int i = 0; i < 10; i++)
         if (v[i]) d = 4'(i);
      return d;
   endfunction

   // NOTE: every variable gets a default before any branch, so no latches are inferred.
   always_comb begin
      sync1_d = keypad;
      sync2_d = sync1_q;
      samp_d  = sync2_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      evt_d   = 1'b0;
      digit_d = digit_q;

      if (sync2_q != samp_q)
         cnt_d = '0;
      else if (cnt_q < CW'(DEBOUNCE))
         cnt_d = cnt_q + 1'b1;

      // The counter saturates, so this qualifies at most once per stable period.
      if (sync2_q == samp_q && cnt_q == CW'(DEBOUNCE - 1)) begin
         if (sync2_q == '0) begin
            armed_d = 1'b1;
         end else if (armed_q && $onehot(sync2_q)) begin
            evt_d   = 1'b1;
            armed_d = 1'b0;
            digit_d = encode(sync2_q);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         samp_q  <= '0;
         cnt_q   <= '0;
         armed_q <= 1'b0;
         evt_q   <= 1'b0;
         digit_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         samp_q  <= samp_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         evt_q   <= evt_d;
         digit_q <= digit_d;
      end
   end

   assign key_evt   = evt_q;
   assign key_digit = digit_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Keypad time-entry sequencer: walks six HH:MM:SS digits, range-checks each,
// and commits a complete time to the watch counters with a one-cycle load.
module time_set_ctrl
   import watch_pkg::*;
#(
   parameter int DEBOUNCE = 20,
   parameter int TIMEOUT  = 10000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  keypad,
   input  logic        set_req,
   output logic        setting,
   output logic [2:0]  cursor,
   output logic [23:0] entry_time,
   output logic        load,
   output logic [23:0] load_time,
   output logic        err,
   output logic        timeout
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic       key_evt;
   logic [3:0] key_digit;

   key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_debounce (
      .clk       (clk),
      .rst       (rst),
      .keypad    (keypad),
      .key_evt   (key_evt),
      .key_digit (key_digit)
   );

   state_e        state_q, state_d;
   logic [2:0]    cursor_q, cursor_d;
   logic [23:0]   entry_q, entry_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          load_q, load_d;
   logic [23:0]   load_time_q, load_time_d;
   logic          err_q, err_d;
   logic          timeout_q, timeout_d;

   always_comb begin
      state_d     = state_q;
      cursor_d    = cursor_q;
      entry_d     = entry_q;
      tcnt_d      = tcnt_q;
      load_d      = 1'b0;
      load_time_d = load_time_q;
      err_d       = 1'b0;
      timeout_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (set_req) begin
               state_d  = ST_ENTRY;
               cursor_d = POS_H_TEN;
               entry_d  = '0;
               tcnt_d   = '0;
            end
         end
         ST_ENTRY: begin
            // A restart outranks both a same-cycle key event and expiry.
            if (set_req) begin
               cursor_d = POS_H_TEN;
               entry_d  = '0;
               tcnt_d   = '0;
            end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
               if (key_evt) begin
                  if (key_digit <= digit_limit(cursor_q, h_ten_of(entry_q))) begin
                     entry_d = put_nibble(entry_q, cursor_q, key_digit);
                     tcnt_d  = '0;
                     if (cursor_q == POS_S_ONE) begin
                        state_d     = ST_COMMIT;
                        cursor_d    = POS_H_TEN;
                        load_d      = 1'b1;
                        load_time_d = entry_d;
                     end else begin
                        cursor_d = cursor_q + 1'b1;
                     end
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
         end
         ST_COMMIT: begin
            // The load strobe is already on the wire during this state.
            if (set_req) begin
               state_d  = ST_ENTRY;
               cursor_d = POS_H_TEN;
               entry_d  = '0;
               tcnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cursor_q    <= '0;
         entry_q     <= '0;
         tcnt_q      <= '0;
         load_q      <= 1'b0;
         load_time_q <= '0;
         err_q       <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cursor_q    <= cursor_d;
         entry_q     <= entry_d;
         tcnt_q      <= tcnt_d;
         load_q      <= load_d;
         load_time_q <= load_time_d;
         err_q       <= err_d;
         timeout_q   <= timeout_d;
      end
   end

   assign setting    = (state_q == ST_ENTRY);
   assign cursor     = cursor_q;
   assign entry_time = entry_q;
   assign load       = load_q;
   assign load_time  = load_time_q;
   assign err        = err_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: scoreboard of committed times plus
// per-scenario checks on cursor, buffer and strobe counts.
module tb_time_set_ctrl;

   localparam int DEB = 4;
   localparam int TO  = 200;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  keypad = '0;
   logic        set_req = 1'b0;
   logic        setting;
   logic [2:0]  cursor;
   logic [23:0] entry_time;
   logic        load;
   logic [23:0] load_time;
   logic        err;
   logic        timeout;

   int vectors = 0;
   int miscompares = 0;
   int load_cnt = 0;
   int err_cnt = 0;
   int to_cnt = 0;
   logic [23:0] exp_q[$];
   logic [23:0] exp_v;

   always #5 clk = ~clk;

   time_set_ctrl #(.DEBOUNCE(DEB), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .keypad     (keypad),
      .set_req    (set_req),
      .setting    (setting),
      .cursor     (cursor),
      .entry_time (entry_time),
      .load       (load),
      .load_time  (load_time),
      .err        (err),
      .timeout    (timeout)
   );

   // Scoreboard side: every load pulse must match the oldest pending entry.
   always @(negedge clk) begin
      if (load) begin
         load_cnt++;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL load_unexpected: load_time=%h, no entry pending", load_time);
         end else begin
            exp_v = exp_q.pop_front();
            if (load_time !== exp_v) begin
               miscompares++;
               $display("FAIL load_time: got %h expected %h", load_time, exp_v);
            end
         end
      end
      if (err) err_cnt++;
      if (timeout) to_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_set();
      set_req = 1'b1;
      tick(1);
      set_req = 1'b0;
   endtask

   task automatic press(input int d);
      keypad = 10'(1 << d);
      tick(10);
      keypad = '0;
      tick(10);
   endtask

   task automatic wait_load(input int l0);
      for (int i = 0; i < 30 && load_cnt == l0; i++) tick(1);
   endtask

   task automatic test_reset();
      #2;
      vectors++;
      if ({setting, cursor, entry_time, load, load_time, err, timeout} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {setting, cursor, entry_time, load, load_time, err, timeout});
      end
      tick(2);
      rst = 1'b1;
      tick(12);
   endtask

   task automatic test_valid_entry();
      int l0, e0;
      l0 = load_cnt;
      e0 = err_cnt;
      exp_q.push_back(24'h123456);
      pulse_set();
      vectors++;
      if (setting !== 1'b1) begin
         miscompares++;
         $display("FAIL valid_setting_rise: got %b expected 1", setting);
      end
      for (int d = 1; d <= 6; d++) press(d);
      wait_load(l0);
      vectors++;
      if (load_cnt - l0 !== 1) begin
         miscompares++;
         $display("FAIL valid_load_count: got %0d expected 1", load_cnt - l0);
      end
      vectors++;
      if (err_cnt !== e0) begin
         miscompares++;
         $display("FAIL valid_no_err: got %0d err pulses expected 0", err_cnt - e0);
      end
      vectors++;
      if ({setting, cursor} !== 4'b0) begin
         miscompares++;
         $display("FAIL valid_idle_after: setting/cursor got %b/%0d expected 0/0", setting, cursor);
      end
      vectors++;
      if (load_time !== 24'h123456 || entry_time !== 24'h123456) begin
         miscompares++;
         $display("FAIL valid_held: load_time %h entry_time %h expected 123456", load_time, entry_time);
      end
   endtask

   task automatic test_range();
      int l0, e0;
      l0 = load_cnt;
      e0 = err_cnt;
      pulse_set();
      press(3);
      vectors++;
      if (err_cnt - e0 !== 1 || cursor !== 3'd0) begin
         miscompares++;
         $display("FAIL range_pos0: err %0d cursor %0d expected 1 and 0", err_cnt - e0, cursor);
      end
      press(2);
      press(4);
      vectors++;
      if (err_cnt - e0 !== 2 || cursor !== 3'd1) begin
         miscompares++;
         $display("FAIL range_pos1: err %0d cursor %0d expected 2 and 1", err_cnt - e0, cursor);
      end
      vectors++;
      if (entry_time !== 24'h200000) begin
         miscompares++;
         $display("FAIL range_buffer: got %h expected 200000", entry_time);
      end
      exp_q.push_back(24'h235959);
      press(3); press(5); press(9); press(5); press(9);
      wait_load(l0);
      vectors++;
      if (load_cnt - l0 !== 1 || err_cnt - e0 !== 2) begin
         miscompares++;
         $display("FAIL range_commit: loads %0d errs %0d expected 1 and 2", load_cnt - l0, err_cnt - e0);
      end
   endtask

   task automatic test_bounce();
      int e0;
      e0 = err_cnt;
      pulse_set();
      for (int i = 0; i < 10; i++) begin
         keypad = (i % 2 == 0) ? 10'b0000000010 : 10'b0;
         tick(2);
      end
      keypad = 10'b0000000010;
      tick(10);
      keypad = '0;
      tick(10);
      vectors++;
      if (cursor !== 3'd1 || entry_time !== 24'h100000) begin
         miscompares++;
         $display("FAIL bounce_single_event: cursor %0d buffer %h expected 1 and 100000", cursor, entry_time);
      end
      keypad = 10'b0000000110;
      tick(20);
      keypad = '0;
      tick(10);
      vectors++;
      if (cursor !== 3'd1 || err_cnt !== e0) begin
         miscompares++;
         $display("FAIL multikey_ignored: cursor %0d errs %0d expected 1 and 0", cursor, err_cnt - e0);
      end
      press(0);
      vectors++;
      if (cursor !== 3'd2 || entry_time !== 24'h100000) begin
         miscompares++;
         $display("FAIL after_multikey: cursor %0d buffer %h expected 2 and 100000", cursor, entry_time);
      end
   endtask

   task automatic test_timeout();
      int l0, t0, n;
      l0 = load_cnt;
      pulse_set();
      press(1);
      press(2);
      t0 = to_cnt;
      vectors++;
      if (cursor !== 3'd2) begin
         miscompares++;
         $display("FAIL timeout_setup_cursor: got %0d expected 2", cursor);
      end
      n = 0;
      while (to_cnt == t0 && n < 300) begin
         tick(1);
         n++;
      end
      vectors++;
      if (to_cnt - t0 !== 1) begin
         miscompares++;
         $display("FAIL timeout_pulse: got %0d pulses expected 1", to_cnt - t0);
      end
      vectors++;
      if (n < 180 || n > 195) begin
         miscompares++;
         $display("FAIL timeout_delay: got %0d idle cycles expected 180..195", n);
      end
      vectors++;
      if (setting !== 1'b0 || load_cnt !== l0) begin
         miscompares++;
         $display("FAIL timeout_abort: setting %b loads %0d expected 0 and 0", setting, load_cnt - l0);
      end
   endtask

   task automatic test_restart();
      int e0, t0;
      pulse_set();
      press(1); press(2); press(3);
      vectors++;
      if (cursor !== 3'd3) begin
         miscompares++;
         $display("FAIL restart_setup: cursor got %0d expected 3", cursor);
      end
      e0 = err_cnt;
      t0 = to_cnt;
      pulse_set();
      vectors++;
      if (cursor !== 3'd0 || entry_time !== 24'h0 || setting !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_clear: cursor %0d buffer %h setting %b expected 0 000000 1",
                  cursor, entry_time, setting);
      end
      tick(5);
      vectors++;
      if (err_cnt !== e0 || to_cnt !== t0) begin
         miscompares++;
         $display("FAIL restart_strobes: errs %0d timeouts %0d expected 0 and 0", err_cnt - e0, to_cnt - t0);
      end
   endtask

   task automatic test_reset_mid();
      int l0, e0;
      l0 = load_cnt;
      e0 = err_cnt;
      pulse_set();
      press(1);
      press(2);
      keypad = 10'b0000100000;
      tick(3);
      rst = 1'b0;
      #1;
      vectors++;
      if ({setting, cursor, entry_time, load, load_time, err, timeout} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got %h expected 0",
                  {setting, cursor, entry_time, load, load_time, err, timeout});
      end
      tick(3);
      rst = 1'b1;
      keypad = '0;
      tick(12);
      press(3);
      tick(5);
      vectors++;
      if ({setting, cursor, entry_time} !== '0 || err_cnt !== e0 || load_cnt !== l0) begin
         miscompares++;
         $display("FAIL idle_keys_ignored: setting %b cursor %0d buffer %h errs %0d loads %0d expected all 0",
                  setting, cursor, entry_time, err_cnt - e0, load_cnt - l0);
      end
   endtask

   initial begin
      test_reset();
      test_valid_entry();
      test_range();
      test_bounce();
      test_timeout();
      test_restart();
      test_reset_mid();
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
